// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the queue entry layout, instruction width and PC step.
// Pure declarations; no timing or backpressure of its own.
package ifq_pkg;

   localparam int          INST_W = 32;
   localparam int          PC_W   = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   // One queued instruction together with the address of its successor.
   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } ifq_entry_t;

   // Force a fetch address onto a word boundary.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Entry storage for the fetch queue: DEPTH slots with wrap-bit pointers.
// Latency: a write is visible at the head on the following cycle.
// Backpressure: none internally; the caller must never write when full.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_en_i,
   input  ifq_entry_t             wr_dat_i,
   input  logic                   rd_en_i,
   input  logic                   flush_i,
   output ifq_entry_t             head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   ifq_entry_t  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_wr;
   logic        do_rd;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (count_o == '0);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Flush drops everything queued by snapping the read pointer to the write pointer.
   always_comb begin
      do_wr    = wr_en_i && !flush_i;
      do_rd    = rd_en_i && !empty_o && !flush_i;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
      rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + (AW+1)'(do_rd);
   end

   // Pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is left uninitialised on reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
      end
   end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: issues sequential I-cache reads, replays misses, flushes on redirect.
// Latency: request to ifq_empty low is 2 cycles; head outputs are combinational.
// Backpressure: fetch is credit-limited (queued + in flight < DEPTH); IFQ_PERF_EN adds perf counters.
module ifq
   import ifq_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] icache_addr,
   output logic        icache_rd_en,
   input  logic [31:0] icache_dout,
   input  logic        icache_valid,
   output logic [31:0] ifq_inst,
   output logic [31:0] ifq_pc_out,
   output logic        ifq_empty,
   input  logic        ifq_rd_en,
   input  logic        ifq_jump_branch_valid,
`ifdef IFQ_PERF_EN
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_empty_cnt,
`endif
   input  logic [31:0] ifq_jump_branch_address
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        inflight_q, inflight_d;

   ifq_entry_t  head;
   ifq_entry_t  wr_entry;
   logic [AW:0] fifo_count;
   logic        fifo_empty;
   logic        flush;
   logic        hit;
   logic        replay;
   logic        issue;
   logic        fifo_wr;
   logic [AW+1:0] occupancy;

   assign flush  = ifq_jump_branch_valid;
   assign hit    = inflight_q && icache_valid;
   assign replay = inflight_q && !icache_valid;

   // Slots already spoken for: queued entries plus the response still on its way.
   assign occupancy = {1'b0, fifo_count} + (AW+2)'(inflight_q);
   assign issue     = !rst && !flush && !replay && (occupancy < (AW+2)'(DEPTH));
   assign fifo_wr   = hit && !flush && !rst;

   assign wr_entry = '{inst: icache_dout, pc: inflight_pc_q + PC_INC};

   assign icache_rd_en = issue;
   assign icache_addr  = fetch_pc_q;
   assign ifq_inst     = head.inst;
   assign ifq_pc_out   = head.pc;
   assign ifq_empty    = fifo_empty || rst;

   // Fetch sequencing: redirect beats replay, replay beats a new sequential request.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = 1'b0;
      if (flush) begin
         fetch_pc_d = align_pc(ifq_jump_branch_address);
      end else if (replay) begin
         fetch_pc_d = inflight_pc_q;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + PC_INC;
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= align_pc(RESET_PC);
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_en_i  (fifo_wr),
      .wr_dat_i (wr_entry),
      .rd_en_i  (ifq_rd_en),
      .flush_i  (flush),
      .head_o   (head),
      .count_o  (fifo_count),
      .empty_o  (fifo_empty)
   );

`ifdef IFQ_PERF_EN
   logic [31:0] perf_flush_q;
   logic [31:0] perf_empty_q;

   // Count redirects taken and starved cycles that were not caused by a redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_flush_q <= '0;
         perf_empty_q <= '0;
      end else begin
         if (flush) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
         if (ifq_empty && !flush) begin
            perf_empty_q <= perf_empty_q + 32'd1;
         end
      end
   end

   assign perf_flush_cnt = perf_flush_q;
   assign perf_empty_cnt = perf_empty_q;
`endif

endmodule

// File: tb/tb_ifq.sv
// Scoreboard bench for ifq: expected requests and entries are queued, a monitor checks them.
// Cycle-exact directed checks cover reset, latency, miss replay, flush and PC wrap.
// Perf counters are exercised only when IFQ_PERF_EN is defined.
module tb_ifq;
   import ifq_pkg::*;

   localparam logic [31:0] K = 32'h5A5A_5A5A;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] icache_addr;
   logic        icache_rd_en;
   logic [31:0] icache_dout = 32'h0;
   logic        icache_valid = 1'b1;
   logic [31:0] ifq_inst;
   logic [31:0] ifq_pc_out;
   logic        ifq_empty;
   logic        ifq_rd_en = 1'b0;
   logic        jb_valid = 1'b0;
   logic [31:0] jb_addr = 32'h0;
`ifdef IFQ_PERF_EN
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_empty_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] exp_req[$];
   ifq_entry_t  exp_ent[$];

   // I-cache model state: request sampled mid-cycle, miss injection by sequence number.
   logic        req_vld_s = 1'b0;
   logic [31:0] req_addr_s = 32'h0;
   logic [31:0] miss_addr = 32'hFFFF_FFFF;
   int          miss_seq = 0;
   int          miss_done = 0;

   ifq #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .icache_addr             (icache_addr),
      .icache_rd_en            (icache_rd_en),
      .icache_dout             (icache_dout),
      .icache_valid            (icache_valid),
      .ifq_inst                (ifq_inst),
      .ifq_pc_out              (ifq_pc_out),
      .ifq_empty               (ifq_empty),
      .ifq_rd_en               (ifq_rd_en),
      .ifq_jump_branch_valid   (jb_valid),
`ifdef IFQ_PERF_EN
      .perf_flush_cnt          (perf_flush_cnt),
      .perf_empty_cnt          (perf_empty_cnt),
`endif
      .ifq_jump_branch_address (jb_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      req_vld_s  = icache_rd_en;
      req_addr_s = icache_addr;
   end

   // One-cycle cache: data = addr ^ K; valid high unless a planned miss hits this request.
   always @(posedge clk) begin
      #1;
      icache_dout = req_addr_s ^ K;
      if (req_vld_s && (miss_seq != miss_done) && (req_addr_s == miss_addr)) begin
         icache_valid = 1'b0;
         miss_done    = miss_done + 1;
      end else begin
         icache_valid = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic push_ent(input logic [31:0] fetch_addr, input logic [31:0] pc_out);
      ifq_entry_t e;
      e.inst = fetch_addr ^ K;
      e.pc   = pc_out;
      exp_ent.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst       = 1'b1;
      ifq_rd_en = 1'b0;
      jb_valid  = 1'b0;
      @(negedge clk);
      chk("rst0_empty", 32'(ifq_empty), 32'd1);
      chk("rst0_rd_en", 32'(icache_rd_en), 32'd0);
      chk("leftover_req", 32'(exp_req.size()), 32'd0);
      chk("leftover_ent", 32'(exp_ent.size()), 32'd0);
      exp_req.delete();
      exp_ent.delete();
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst1_empty", 32'(ifq_empty), 32'd1);
      chk("rst1_rd_en", 32'(icache_rd_en), 32'd0);
      chk("rst1_addr", icache_addr, 32'h0000_0000);
`ifdef IFQ_PERF_EN
      chk("rst_perf_flush", perf_flush_cnt, 32'd0);
      chk("rst_perf_empty", perf_empty_cnt, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Pop n entries, asserting ifq_rd_en only on cycles with data.
   task automatic pop_n(input int n);
      int got   = 0;
      int guard = 0;
      while (got < n && guard < 100) begin
         @(posedge clk); #1;
         if (!ifq_empty) begin
            ifq_rd_en = 1'b1;
            got++;
         end else begin
            ifq_rd_en = 1'b0;
         end
         guard++;
      end
      @(posedge clk); #1;
      ifq_rd_en = 1'b0;
      chk("pop_budget", 32'(got), 32'(n));
   endtask

   initial begin
      fork
         begin : monitor
            logic [31:0] ea;
            ifq_entry_t  ee;
            forever begin
               @(negedge clk);
               if (!rst) begin
                  if (icache_rd_en && exp_req.size() > 0) begin
                     ea = exp_req.pop_front();
                     chk("req_addr", icache_addr, ea);
                  end
                  if (ifq_rd_en && !ifq_empty && !jb_valid) begin
                     if (exp_ent.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_pop: got pc_out %h expected no pop", ifq_pc_out);
                     end else begin
                        ee = exp_ent.pop_front();
                        chk("pop_inst", ifq_inst, ee.inst);
                        chk("pop_pc_out", ifq_pc_out, ee.pc);
                     end
                  end
               end
            end
         end
      join_none

      // Fill from reset with all hits and no pops.
      do_reset();
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'hC);
      @(negedge clk);
      chk("t1_c0_rd_en", 32'(icache_rd_en), 32'd1);
      chk("t1_c0_addr", icache_addr, 32'h0);
      @(negedge clk);
      chk("t1_c1_empty", 32'(ifq_empty), 32'd1);
      @(negedge clk);
      chk("t1_c2_empty", 32'(ifq_empty), 32'd0);
      @(negedge clk);
      chk("t1_c3_rd_en", 32'(icache_rd_en), 32'd1);
      @(negedge clk);
      chk("t1_c4_rd_en", 32'(icache_rd_en), 32'd0);
      @(negedge clk);
      chk("t1_c5_rd_en", 32'(icache_rd_en), 32'd0);
      chk("t1_head_pc", ifq_pc_out, 32'h4);
      chk("t1_head_inst", ifq_inst, 32'h5A5A_5A5A);
      push_ent(32'h0, 32'h4);
      push_ent(32'h4, 32'h8);
      push_ent(32'h8, 32'hC);
      push_ent(32'hC, 32'h10);
      pop_n(4);

      // Miss at 0x8 with pops attempted while empty.
      do_reset();
      miss_addr = 32'h8;
      miss_seq  = miss_seq + 1;
      ifq_rd_en = 1'b1;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'hC);
      @(negedge clk);
      @(negedge clk);
      chk("t2_c1_empty", 32'(ifq_empty), 32'd1);
      @(posedge clk); #1;
      ifq_rd_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t2_replay_rd_en", 32'(icache_rd_en), 32'd0);
      @(negedge clk);
      chk("t2_rereq_rd_en", 32'(icache_rd_en), 32'd1);
      chk("t2_rereq_addr", icache_addr, 32'h8);
      push_ent(32'h0, 32'h4);
      push_ent(32'h4, 32'h8);
      push_ent(32'h8, 32'hC);
      push_ent(32'hC, 32'h10);
      pop_n(4);

      // Full queue, pop every cycle: one instruction per cycle.
      do_reset();
      for (int i = 0; i < 8; i++) exp_req.push_back(32'(i * 4));
      repeat (7) @(negedge clk);
      for (int i = 0; i < 16; i++) push_ent(32'(i * 4), 32'(i * 4 + 4));
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         ifq_rd_en = 1'b1;
         @(negedge clk);
         chk("t3_not_empty", 32'(ifq_empty), 32'd0);
      end
      @(posedge clk); #1;
      ifq_rd_en = 1'b0;

      // Flush to 0x1003 with three queued, one in flight, pop attempted.
      do_reset();
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'hC);
      exp_req.push_back(32'h1000);
      repeat (4) begin
         @(posedge clk); #1;
      end
      jb_valid  = 1'b1;
      jb_addr   = 32'h0000_1003;
      ifq_rd_en = 1'b1;
      @(negedge clk);
      chk("t4_flush_rd_en", 32'(icache_rd_en), 32'd0);
      @(posedge clk); #1;
      jb_valid  = 1'b0;
      ifq_rd_en = 1'b0;
      @(negedge clk);
      chk("t4_post_empty", 32'(ifq_empty), 32'd1);
      chk("t4_post_rd_en", 32'(icache_rd_en), 32'd1);
      chk("t4_post_addr", icache_addr, 32'h1000);
      push_ent(32'h1000, 32'h1004);
      pop_n(1);

      // Back-to-back flushes: the second target wins.
      @(posedge clk); #1;
      jb_valid = 1'b1;
      jb_addr  = 32'h0000_2000;
      @(negedge clk);
      chk("t6_f0_rd_en", 32'(icache_rd_en), 32'd0);
      @(posedge clk); #1;
      jb_addr = 32'h0000_300B;
      exp_req.push_back(32'h3008);
      exp_req.push_back(32'h300C);
      @(negedge clk);
      chk("t6_f1_rd_en", 32'(icache_rd_en), 32'd0);
      @(posedge clk); #1;
      jb_valid = 1'b0;
      @(negedge clk);
      chk("t6_resume_rd_en", 32'(icache_rd_en), 32'd1);
      chk("t6_resume_addr", icache_addr, 32'h3008);
      chk("t6_resume_empty", 32'(ifq_empty), 32'd1);
      push_ent(32'h3008, 32'h300C);
      pop_n(1);

      // Fetch address wrap from 0xFFFF_FFFC.
      @(posedge clk); #1;
      jb_valid = 1'b1;
      jb_addr  = 32'hFFFF_FFFC;
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      @(posedge clk); #1;
      jb_valid = 1'b0;
      push_ent(32'hFFFF_FFFC, 32'h0);
      push_ent(32'h0, 32'h4);
      pop_n(2);

`ifdef IFQ_PERF_EN
      // Two flushes and five starved cycles, then a reset clears the counters.
      do_reset();
      miss_addr = 32'h40;
      miss_seq  = miss_seq + 1;
      @(posedge clk); #1;
      jb_valid = 1'b1;
      jb_addr  = 32'h40;
      @(posedge clk); #1;
      @(posedge clk); #1;
      jb_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("perf_flush", perf_flush_cnt, 32'd2);
      chk("perf_empty", perf_empty_cnt, 32'd5);
      chk("perf_not_empty", 32'(ifq_empty), 32'd0);
`endif

      do_reset();
      chk("end_req_left", 32'(exp_req.size()), 32'd0);
      chk("end_ent_left", 32'(exp_ent.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
